// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result handshake bundle between a requester and the divider
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_zero;
    logic               overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 2*WIDTH-bit dividend into WIDTH-bit quotient/remainder
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               div_zero_q;
    logic               overflow_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   q_d;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;

    // One restoring step: shifted partial remainder minus divisor, the borrow bit decides restore
    always_comb begin
        diff = {r_q, q_q[WIDTH-1]} - {1'b0, divisor_q};
        r_d  = diff[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : diff[WIDTH-1:0];
        q_d  = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Control FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        div_zero_q <= 1'b0;
                        overflow_q <= 1'b0;
                        cnt_q      <= '0;
                        divisor_q  <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            div_zero_q  <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[WIDTH-1:0];
                        end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            overflow_q  <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                        end else begin
                            state_q <= CALC;
                            r_q     <= bus.dividend[2*WIDTH-1:WIDTH];
                            q_q     <= bus.dividend[WIDTH-1:0];
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and round-trip checks of the sequential divider
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    seq_divider_if #(.WIDTH(16)) bus ();

    seq_divider #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present an operation, hold until accepted, then scramble inputs and wait for out_valid
    task automatic start_op(input logic [31:0] a, input logic [15:0] b);
        int n;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = b ^ 16'h5A5A;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [15:0] q, input logic [15:0] r,
                                input logic dz, input logic ov);
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || lat != exp_lat) begin
            err_cnt++;
            $display("FAIL %s latency: got %0d valid=%b, expected %0d", name, lat, bus.out_valid, exp_lat);
        end
        vec_cnt++;
        if (bus.quotient !== q) begin
            err_cnt++;
            $display("FAIL %s quotient: got %0d, expected %0d", name, bus.quotient, q);
        end
        vec_cnt++;
        if (bus.remainder !== r) begin
            err_cnt++;
            $display("FAIL %s remainder: got %0d, expected %0d", name, bus.remainder, r);
        end
        vec_cnt++;
        if (bus.div_zero !== dz || bus.overflow !== ov) begin
            err_cnt++;
            $display("FAIL %s flags: got dz=%b ov=%b, expected dz=%b ov=%b", name, bus.div_zero, bus.overflow, dz, ov);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 16'd0 ||
            bus.remainder !== 16'd0 || bus.div_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: got rdy=%b vld=%b q=%0d r=%0d dz=%b ov=%b, expected 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero, bus.overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        logic [31:0] dvd [6] = '{32'd123456, 32'd4294836225, 32'd1000, 32'd0, 32'hFFFE_FFFF, 32'h0004_FFFF};
        logic [15:0] dvs [6] = '{16'd789, 16'hFFFF, 16'd7, 16'd5, 16'hFFFF, 16'd5};
        logic [15:0] eq  [6] = '{16'd156, 16'hFFFF, 16'd142, 16'd0, 16'hFFFF, 16'hFFFF};
        logic [15:0] er  [6] = '{16'd372, 16'd0, 16'd6, 16'd0, 16'hFFFE, 16'd4};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_op(dvd[i], dvs[i]);
            wait_done(lat);
            check_result($sformatf("normal%0d", i), lat, 16, eq[i], er[i], 1'b0, 1'b0);
            take();
        end
    endtask

    task automatic test_errors;
        logic [31:0] dvd [4] = '{32'd100, 32'h0001_0000, 32'h0005_0000, 32'hDEAD_BEEF};
        logic [15:0] dvs [4] = '{16'd0, 16'd1, 16'd5, 16'd0};
        logic [15:0] er  [4] = '{16'd100, 16'd0, 16'd0, 16'hBEEF};
        logic        edz [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(dvd[i], dvs[i]);
            wait_done(lat);
            check_result($sformatf("error%0d", i), lat, 0, 16'hFFFF, er[i], edz[i], ~edz[i]);
            take();
        end
    endtask

    task automatic test_stall;
        int lat;
        start_op(32'd1000, 16'd7);
        wait_done(lat);
        bus.in_valid = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vec_cnt++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 16'd142 ||
                bus.remainder !== 16'd6 || bus.div_zero !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall%0d: got vld=%b rdy=%b q=%0d r=%0d dz=%b, expected 1 0 142 6 0",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_zero);
            end
        end
        bus.in_valid = 1'b0;
        take();
        vec_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 16'd142 || bus.remainder !== 16'd6) begin
            err_cnt++;
            $display("FAIL stall_release: got rdy=%b vld=%b q=%0d r=%0d, expected 1 0 142 6",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(32'd123456, 16'd789);
        wait_done(lat);
        bus.dividend  = 32'd1000;
        bus.divisor   = 16'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        vec_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_take: got rdy=%b vld=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        vec_cnt++;
        if (bus.in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_accept: got rdy=%b, expected 0", bus.in_ready);
        end
        wait_done(lat);
        check_result("b2b", lat, 16, 16'd142, 16'd6, 1'b0, 1'b0);
        take();
    endtask

    task automatic test_reset_mid;
        int seen;
        start_op(32'd123456, 16'd789);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 16'd0 ||
            bus.remainder !== 16'd0 || bus.div_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid: got rdy=%b vld=%b q=%0d r=%0d dz=%b ov=%b, expected 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero, bus.overflow);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        vec_cnt++;
        if (seen != 0) begin
            err_cnt++;
            $display("FAIL reset_mid_no_result: got %0d valid cycles, expected 0", seen);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [15:0] b;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(1, 65535));
            start_op(32'(a) * 32'(b), b);
            wait_done(lat);
            vec_cnt++;
            if (lat != 16 || bus.quotient !== a || bus.remainder !== 16'd0 || bus.div_zero !== 1'b0 || bus.overflow !== 1'b0) begin
                err_cnt++;
                $display("FAIL random%0d %0d*%0d: got lat=%0d q=%0d r=%0d dz=%b ov=%b, expected 16 %0d 0 0 0",
                         i, a, b, lat, bus.quotient, bus.remainder, bus.div_zero, bus.overflow, a);
            end
            take();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_normal();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
